// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : PC owner and fetch issue control for a 1-cycle imem,
//                   with a 2-entry skid FIFO toward decode.
// Revision        : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    entry_t [1:0]      fifo_q, fifo_d;
    logic [1:0]        count_q, count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              wr_idx;
    logic [2:0]        credit_sum;

    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid & out_ready;
    assign push       = inflight_q & ~redirect_valid;
    assign credit_sum = {1'b0, count_q} + {2'b00, inflight_q};

    // Reserve a FIFO slot for every outstanding read so a returning word
    // always has somewhere to land.
    assign issue = (state_q == ST_RUN) & fetch_en & ~redirect_valid &
                   (credit_sum < (3'd2 + {2'b00, pop}));

    // Head lives in slot 0; a push lands just behind whatever survives the pop.
    assign wr_idx = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop);

    always_comb begin
        state_d       = fetch_en ? ST_RUN : ST_IDLE;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        fifo_d        = fifo_q;
        count_d       = count_q;

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + ADDR_W'(PC_STEP);
                inflight_pc_d = pc_q;
            end
            if (pop) begin
                fifo_d[0] = fifo_q[1];
            end
            if (push) begin
                fifo_d[wr_idx].pc    = inflight_pc_q;
                fifo_d[wr_idx].instr = imem_data;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fifo_q        <= '0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fifo_q        <= fifo_d;
            count_q       <= count_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_instr = fifo_q[0].instr;
    assign out_pc    = fifo_q[0].pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed vector table plus async-reset sequence.
// Revision           : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [64];

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ov;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    fetch_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    // Big-endian byte memory for low addresses; an address hash elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd61)
            return {mem[a[5:0]], mem[a[5:0] + 6'd1], mem[a[5:0] + 6'd2], mem[a[5:0] + 6'd3]};
        else
            return a ^ 32'hA5A5_A5A5;
    endfunction

    always @(posedge clk) imem_data <= word_at(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ov, input logic [31:0] addr, input logic [31:0] pc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ov = ov; v.addr = addr; v.pc = pc; v.instr = word_at(pc);
        vecs.push_back(v);
    endtask

    initial begin
        mem[0] = 8'hD1; mem[1] = 8'h18; mem[2] = 8'hD1; mem[3] = 8'h18;
        mem[4] = 8'h18; mem[5] = 8'hD1; mem[6] = 8'h18; mem[7] = 8'h18;
        for (int i = 8; i < 64; i++) mem[i] = 8'(i * 7 + 3);

        // fe, rdy, rv, rpc : expected out_valid, imem_addr, out_pc
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd4,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd8,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 32'd4);
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd12, 32'd4);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd16, 32'd8);
        add(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'd0,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd4,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd8,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 32'd4);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 32'd8);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd12, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'd12, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd12, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd16, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd20, 32'd12);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd24, 32'd16);
        add(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd0,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd4,  32'hFFFF_FFFC);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd8,  32'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 32'd4);

        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset imem_addr", imem_addr, 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset out_pc",    out_pc,    32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            fetch_en       = vecs[i].fe;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
            if (vecs[i].ov) begin
                check($sformatf("row%0d out_pc", i),    out_pc,    vecs[i].pc);
                check($sformatf("row%0d out_instr", i), out_instr, vecs[i].instr);
            end
        end

        // Fill the FIFO, then hit reset between edges.
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("full imem_addr", imem_addr, 32'd12);
        check("full out_pc",    out_pc,    32'd4);
        #3;
        rst_n = 1'b0;
        #2;
        check("async out_valid", {31'd0, out_valid}, 32'd0);
        check("async imem_addr", imem_addr, 32'd0);
        check("async out_instr", out_instr, 32'd0);
        check("async out_pc",    out_pc,    32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("restart early out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("restart out_valid", {31'd0, out_valid}, 32'd1);
        check("restart out_pc",    out_pc,    32'd0);
        check("restart out_instr", out_instr, 32'hD118_D118);
        @(posedge clk);
        #1;
        check("restart next out_pc",    out_pc,    32'd4);
        check("restart next out_instr", out_instr, 32'h18D1_1818);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
